// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with PC register, instruction-memory
// request handshake and IF/ID pipeline register.
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   reset        - asynchronous active-high reset
//   stall        - hazard hold from decode; freezes PC and IF/ID
//   redirect     - branch/jump taken; reload PC from redirect_pc
//   redirect_pc  - redirect target; bits [1:0] are forced to zero
//   imem_req     - instruction memory request (combinational)
//   imem_addr    - fetch address (the PC register)
//   imem_ready   - memory response valid; only honoured while imem_req=1
//   imem_rdata   - instruction word returned by memory
//   if_valid     - IF/ID holds a real instruction
//   if_instr     - IF/ID instruction word (zero / NOP when not valid)
//   if_pc_plus4  - address of the captured instruction plus 4
//   opcode       - if_instr[31:26] for the main decoder
//
// Build option:
//   FETCH_DELAY_SLOT_EN - MIPS branch-delay-slot semantics. When undefined
//   the instruction following a taken branch is flushed; when defined the
//   next fetched word is kept as the delay slot and the target is applied
//   after it (a redirect seen before that word arrives is held pending).

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic [5:0]  opcode
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, REDIR} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        accept;
    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;

`ifdef FETCH_DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
`endif

    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4  = pc_q + 32'd4;
    assign accept    = imem_req && imem_ready;

    // Next-state and memory request
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
`ifdef FETCH_DELAY_SLOT_EN
                // The delay slot is still fetched while a redirect is seen.
                imem_req = !stall;
                if (stall) state_d = HOLD;
`else
                imem_req = !stall && !redirect;
                if (redirect)   state_d = REDIR;
                else if (stall) state_d = HOLD;
`endif
            end
            HOLD: begin
`ifdef FETCH_DELAY_SLOT_EN
                if (!stall) state_d = FETCH;
`else
                if (redirect)    state_d = REDIR;
                else if (!stall) state_d = FETCH;
`endif
            end
            REDIR: begin
                if (!redirect) state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    // PC and IF/ID datapath
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
`ifdef FETCH_DELAY_SLOT_EN
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;

        // IF/ID ignores redirect entirely: it only holds on stall.
        if (!stall) begin
            if (accept) begin
                instr_d = imem_rdata;
                valid_d = 1'b1;
                pc4_d   = pc_plus4;
            end else begin
                instr_d = '0;
                valid_d = 1'b0;
            end
        end

        // After a delay-slot accept the PC jumps to the newest known target.
        if (accept) begin
            pend_d = 1'b0;
            if (redirect)    pc_d = redir_tgt;
            else if (pend_q) pc_d = pend_pc_q;
            else             pc_d = pc_plus4;
        end else if (redirect) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_tgt;
        end
`else
        if (redirect) begin
            pc_d    = redir_tgt;
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            if (accept) begin
                instr_d = imem_rdata;
                valid_d = 1'b1;
                pc4_d   = pc_plus4;
                pc_d    = pc_plus4;
            end else begin
                // Unstalled cycle without a capture: decode consumed the old
                // entry, so a bubble is inserted.
                instr_d = '0;
                valid_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end
`endif

    assign imem_addr   = pc_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc_plus4 = pc4_q;
    assign opcode      = instr_q[31:26];

endmodule
